// File: rtl/and_arb_pkg.sv
// Shared constants for the AND-chain arbiter: FSM state codes, default
// requester count and the matching requester-index width.
package and_arb_pkg;

  localparam int NREQ_DEF = 4;
  localparam int ID_W     = $clog2(NREQ_DEF);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_EVAL = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

endpackage

// File: rtl/and_chain_unit.sv
// Shared combinational AND chain: d = a & b, e = c & d.
module and_chain_unit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic d,
  output logic e
);

  assign d = a & b;
  assign e = c & d;

endmodule

// File: rtl/and_chain_arbiter.sv
// Round-robin arbiter time-sharing one AND-chain unit among NREQ requesters.
// Each transaction walks IDLE -> LOAD -> EVAL -> RESP, four cycles in all.
module and_chain_arbiter
  import and_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          a_in,
  input  logic [NREQ-1:0]          b_in,
  input  logic [NREQ-1:0]          c_in,
  output logic [NREQ-1:0]          grant,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic                     d_out,
  output logic                     e_out
);

  localparam int IDW = $clog2(NREQ);

  logic [1:0]     state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic [IDW-1:0] win_c;
  logic           found;
  logic           op_a, op_b, op_c;
  logic           d_c, e_c;

  // First set request bit at or after ptr, wrapping past NREQ-1.
  always_comb begin : rr_scan
    int j;
    found = 1'b0;
    win_c = '0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        win_c = IDW'(j);
      end
    end
  end

  and_chain_unit u_chain (
    .a (op_a),
    .b (op_b),
    .c (op_c),
    .d (d_c),
    .e (e_c)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      ptr     <= '0;
      win     <= '0;
      grant   <= '0;
      done    <= 1'b0;
      done_id <= '0;
      d_out   <= 1'b0;
      e_out   <= 1'b0;
      op_a    <= 1'b0;
      op_b    <= 1'b0;
      op_c    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            grant <= NREQ'(1) << win_c;
            win   <= win_c;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Operands are frozen here; later input changes are ignored.
          op_a  <= a_in[win];
          op_b  <= b_in[win];
          op_c  <= c_in[win];
          state <= ST_EVAL;
        end
        ST_EVAL: begin
          d_out   <= d_c;
          e_out   <= e_c;
          done_id <= win;
          done    <= 1'b1;
          state   <= ST_RESP;
        end
        ST_RESP: begin
          done  <= 1'b0;
          grant <= '0;
          ptr   <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_and_chain_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic, compared
// every cycle against a transaction-level round-robin reference model.
module tb_and_chain_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] req, a, b, c;
  logic [N-1:0] grant;
  logic         busy, done, d_out, e_out;
  logic [1:0]   done_id;

  int n_chk = 0;
  int n_err = 0;

  // reference model: transaction age (0 = free), owner, captured operands
  int   m_age, m_owner, m_ptr, m_id;
  logic m_a, m_b, m_c, m_done, m_d, m_e;
  logic [N-1:0] m_grant;

  and_chain_arbiter #(.NREQ(N)) dut (
    .clk     (clk),
    .reset_n (rst_n),
    .req     (req),
    .a_in    (a),
    .b_in    (b),
    .c_in    (c),
    .grant   (grant),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .d_out   (d_out),
    .e_out   (e_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++)
      if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction

  task automatic model_edge();
    if (!rst_n) begin
      m_age = 0; m_owner = 0; m_ptr = 0; m_id = 0;
      m_a = 0; m_b = 0; m_c = 0; m_done = 0; m_d = 0; m_e = 0; m_grant = '0;
    end else begin
      case (m_age)
        0: if (req != '0) begin
             m_owner = rr_pick(req, m_ptr);
             m_grant = N'(1) << m_owner;
             m_age   = 1;
           end
        1: begin
             m_a = a[m_owner]; m_b = b[m_owner]; m_c = c[m_owner];
             m_age = 2;
           end
        2: begin
             m_d = m_a & m_b; m_e = m_c & m_a & m_b; m_id = m_owner;
             m_done = 1; m_age = 3;
           end
        default: begin
             m_done = 0; m_grant = '0; m_ptr = (m_owner + 1) % N; m_age = 0;
           end
      endcase
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("grant", grant, m_grant);
    chk("busy", busy, m_age != 0);
    chk("done", done, m_done);
    chk("done_id", done_id, m_id);
    chk("d_out", d_out, m_d);
    chk("e_out", e_out, m_e);
    chk("onehot", $countones(grant) <= 1, 1);
  endtask

  task automatic drive(input logic r_n, input logic [N-1:0] rq,
                       input logic [N-1:0] va, input logic [N-1:0] vb, input logic [N-1:0] vc);
    rst_n = r_n; req = rq; a = va; b = vb; c = vc;
  endtask

  int pulses;

  initial begin
    drive(0, '0, '0, '0, '0);
    step(); step();
    chk("rst_grant", grant, 0);
    chk("rst_outs", {busy, done, done_id, d_out, e_out}, 0);

    // single request, all operands high
    drive(1, 4'b0001, 4'b0001, 4'b0001, 4'b0001);
    step();
    chk("single_grant", grant, 4'b0001);
    drive(1, 4'b0000, 4'b0001, 4'b0001, 4'b0001);
    step(); step();
    chk("single_done", done, 1);
    chk("single_res", {done_id, d_out, e_out}, {2'd0, 1'b1, 1'b1});
    step();
    chk("single_idle", {busy, done}, 0);
    chk("single_hold", {done_id, d_out, e_out}, {2'd0, 1'b1, 1'b1});

    // mixed operands on requester 2
    drive(1, 4'b0100, 4'b0100, 4'b0100, 4'b0000);
    step(); step(); step();
    chk("mixed1_res", {done, done_id, d_out, e_out}, {1'b1, 2'd2, 1'b1, 1'b0});
    drive(1, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
    step();
    drive(1, 4'b0100, 4'b0000, 4'b0100, 4'b0100);
    step(); step(); step();
    chk("mixed2_res", {done, done_id, d_out, e_out}, {1'b1, 2'd2, 1'b0, 1'b0});
    step();

    // fairness from ptr 0
    drive(0, '0, '0, '0, '0);
    step();
    drive(1, 4'b1111, 4'b1111, 4'b1111, 4'b1111);
    pulses = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (done) pulses++;
      if (i % 4 == 0) chk("fair_grant", grant, 4'b0001 << (i / 4));
    end
    chk("fair_pulses", pulses, 4);

    // wrap-around: serve 2, then 3 before 0
    drive(1, 4'b0100, '0, '0, '0);
    step();
    drive(1, 4'b0000, '0, '0, '0);
    step(); step(); step();
    drive(1, 4'b1001, 4'b1001, 4'b1001, 4'b1001);
    step();
    chk("wrap_first", grant, 4'b1000);
    step(); step(); step(); step();
    chk("wrap_second", grant, 4'b0001);
    drive(1, 4'b0000, '0, '0, '0);
    step(); step(); step();

    // reset while in EVAL
    drive(1, 4'b0010, 4'b0010, 4'b0010, 4'b0010);
    step(); step();
    drive(0, 4'b0010, 4'b0010, 4'b0010, 4'b0010);
    step();
    chk("rst_mid", {grant, busy, done, done_id, d_out, e_out}, 0);
    drive(1, 4'b0010, 4'b0010, 4'b0010, 4'b0010);
    step();
    chk("rst_after_grant", grant, 4'b0010);
    drive(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step(); step();
    chk("rst_after_done", {done, d_out}, 2'b10);
    step();

    // operand toggle after LOAD and req dropped after grant
    drive(1, 4'b0001, 4'b0001, 4'b0001, 4'b0001);
    step(); step();
    drive(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step();
    chk("hold_done", {done, d_out, e_out}, 3'b111);
    step();

    // randomized traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 40) != 0,
            ($urandom % 4 == 0) ? 4'b0000 : N'($urandom),
            N'($urandom), N'($urandom), N'($urandom));
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/and_chain_arbiter.md
AND_CHAIN_ARBITER -- requirements
Module: and_chain_arbiter

Interface
REQ-001 Parameter NREQ, default 4, meaning the number of requesters sharing the AND-chain unit (legal range 2..8).
REQ-002 clk  input  1  sole clock; all state updates occur on its rising edge.
REQ-003 reset_n  input  1  reset, synchronous, active-low.
REQ-004 req  input  NREQ  per-requester request; bit i high means requester i wants one evaluation.
REQ-005 a_in, b_in, c_in  input  NREQ each  per-requester operands; bit i belongs to requester i.
REQ-006 grant  output  NREQ  one-hot, registered; marks the requester currently owning the unit.
REQ-007 busy  output  1  high whenever the state is not IDLE.
REQ-008 done  output  1  one-cycle pulse marking a valid result.
REQ-009 done_id  output  clog2(NREQ)  index of the requester whose result is presented.
REQ-010 d_out, e_out  output  1 each  registered results: d = a&b and e = c&d.

Function
REQ-011 The FSM SHALL have four states: IDLE, LOAD, EVAL and RESP.
REQ-012 In IDLE, when req is nonzero at a rising edge, the FSM SHALL move to LOAD and set grant to the one-hot winner.
REQ-013 Winner selection SHALL be round-robin: scan starts at index ptr and wraps past NREQ-1 to 0; the first set req bit wins.
REQ-014 In LOAD, the FSM SHALL latch a_in, b_in and c_in of the granted index into internal registers, then go to EVAL.
REQ-015 In EVAL, the FSM SHALL register d_out and e_out from the latched operands, set done_id, assert done, then go to RESP.
REQ-016 In RESP, done SHALL be high for exactly this one cycle; at the next edge grant clears, ptr becomes (winner+1) mod NREQ, and the state returns to IDLE.
REQ-017 Latency: req sampled at edge k gives grant visible from k+1 and done visible from k+3; occupancy is 4 cycles per transaction.
REQ-018 Operand changes after the LOAD edge SHALL NOT affect the result.
REQ-019 A requester dropping req after being granted SHALL NOT abort the transaction; it completes normally.
REQ-020 req bits set while busy are not queued; they are only re-evaluated in IDLE.
REQ-021 d_out, e_out and done_id SHALL hold their values after done falls, until the next EVAL edge.
REQ-022 With all req bits low, the FSM SHALL stay in IDLE with grant = 0.
REQ-023 grant SHALL never have more than one bit set.

Reset
REQ-024 When reset_n is low at a rising edge: state = IDLE, ptr = 0, grant = 0, busy = 0, done = 0, done_id = 0, d_out = 0, e_out = 0, operand registers = 0.
REQ-025 Reset asserted mid-transaction (LOAD, EVAL or RESP) SHALL abandon the transaction with no done pulse.
REQ-026 The first edge after reset_n returns high SHALL be a normal IDLE evaluation.

Structure
REQ-027 A shared package and_arb_pkg SHALL hold the state enumeration, the NREQ default and the ID width constant.
REQ-028 The combinational AND chain SHALL be a sub-module, and_chain_unit, with inputs a, b, c and outputs d = a&b, e = c&d, instantiated once.
REQ-029 The round-robin pointer and the FSM SHALL reside in and_chain_arbiter.

Verification
REQ-030 Single request: req=0001, a/b/c[0]=1/1/1 -> grant=0001 at k+1; done at k+3 with done_id=0, d_out=1, e_out=1.
REQ-031 Mixed operands: req=0100, a/b/c[2]=1/1/0 -> done_id=2, d_out=1, e_out=0; with a[2]=0 -> d_out=0, e_out=0.
REQ-032 Fairness: req=1111 held for 16 cycles -> grant sequence 0001, 0010, 0100, 1000, four done pulses 4 cycles apart.
REQ-033 Wrap-around: ptr=3 (after serving requester 2), req=1001 -> requester 3 is granted first, then requester 0.
REQ-034 Reset mid-EVAL: reset_n low for 1 cycle -> no done pulse, all outputs 0, ptr=0; next req=0010 -> grant=0010.
REQ-035 Operand hold: a_in toggled during EVAL -> result reflects the LOAD-edge value; req dropped after grant -> done still pulses.
